st_burst_clock_gen: RTL and testbench

- Synchronous, parametrised generator of ST-bus burst clocks.
- Driven by the 8.192 MHz system clock c8 (one tick = 122 ns) and the active-low frame sync f0.
- On every f0 falling edge it opens a TX and an RX window. Each window has its own delay, pulse count and trailing-pulse count, and drives an enable and a burst bit clock.
- Sits between the frame-sync input and the serial TX/RX shifters.

---
 rtl/st_burst_clock_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_st_burst_clock_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_burst_clock_gen.sv
// ST-bus burst clock generator: each f0 falling edge opens a TX and an RX
// window, each with its own delay, burst pulse count and trailing pulses.

module st_burst_chan #(
  parameter int CNT_W     = 12,
  parameter int HALF      = 2,
  parameter int EN_TAIL   = 1,
  parameter int TRAIL_GAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] pulses,
  input  logic [CNT_W-1:0] trail,
  output logic             en,
  output logic             clk_o,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    BURST = 3'd2,
    TAIL  = 3'd3,
    GAP   = 3'd4,
    TRAIL = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] TAIL_M1 = CNT_W'(EN_TAIL - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(TRAIL_GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] pulses_q;
  logic [CNT_W-1:0] trail_q;

  assign state_dbg = state;

  // tick_cnt holds the ticks left in the current state/phase; pulse_cnt the
  // pulses left after the one in progress. clk_o doubles as the phase bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en        <= 1'b0;
      clk_o     <= 1'b0;
      tick_cnt  <= '0;
      pulse_cnt <= '0;
      pulses_q  <= '0;
      trail_q   <= '0;
    end else if (start) begin
      // A start from any state restarts the window; en stays high throughout.
      en       <= 1'b1;
      pulses_q <= pulses;
      trail_q  <= trail;
      if (dly != '0) begin
        state    <= DELAY;
        clk_o    <= 1'b0;
        tick_cnt <= dly - ONE;
      end else begin
        state     <= BURST;
        clk_o     <= 1'b1;
        tick_cnt  <= HALF_M1;
        pulse_cnt <= pulses - ONE;
      end
    end else begin
      case (state)
        IDLE: begin
          en    <= 1'b0;
          clk_o <= 1'b0;
        end
        DELAY: begin
          if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - ONE;
          end else begin
            state     <= BURST;
            clk_o     <= 1'b1;
            tick_cnt  <= HALF_M1;
            pulse_cnt <= pulses_q - ONE;
          end
        end
        BURST: begin
          if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - ONE;
          end else if (clk_o) begin
            clk_o <= 1'b0;
            // The low half of the last burst period is absorbed into TAIL.
            if (pulse_cnt == '0) begin
              state    <= TAIL;
              tick_cnt <= TAIL_M1;
            end else begin
              tick_cnt <= HALF_M1;
            end
          end else begin
            clk_o     <= 1'b1;
            tick_cnt  <= HALF_M1;
            pulse_cnt <= pulse_cnt - ONE;
          end
        end
        TAIL: begin
          if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - ONE;
          end else begin
            en <= 1'b0;
            if (trail_q == '0) begin
              state <= IDLE;
            end else begin
              state    <= GAP;
              tick_cnt <= GAP_M1;
            end
          end
        end
        GAP: begin
          if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - ONE;
          end else begin
            state     <= TRAIL;
            clk_o     <= 1'b1;
            tick_cnt  <= HALF_M1;
            pulse_cnt <= trail_q - ONE;
          end
        end
        TRAIL: begin
          if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - ONE;
          end else if (clk_o) begin
            clk_o    <= 1'b0;
            tick_cnt <= HALF_M1;
          end else if (pulse_cnt == '0) begin
            state <= IDLE;
          end else begin
            clk_o     <= 1'b1;
            tick_cnt  <= HALF_M1;
            pulse_cnt <= pulse_cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          en    <= 1'b0;
          clk_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

module st_burst_clock_gen #(
  parameter int HALF      = 2,
  parameter int TX_DLY    = 1,
  parameter int TX_PULSES = 31,
  parameter int TX_TRAIL  = 1,
  parameter int RX_DLY    = 4,
  parameter int RX_PULSES = 32,
  parameter int RX_TRAIL  = 0,
  parameter int EN_TAIL   = 1,
  parameter int TRAIL_GAP = 1,
  parameter int CNT_W     = 12
) (
  input  logic c8,
  input  logic rst_n,
  input  logic f0,
  input  logic select,
  output logic clk_en_tx,
  output logic clk_tx,
  output logic clk_en_rx,
  output logic clk_rx,
  output logic busy,
  output logic frame_err
);

  localparam logic [2:0]       ST_IDLE    = 3'd0;
  localparam logic [CNT_W-1:0] TX_DLY_C   = CNT_W'(TX_DLY);
  localparam logic [CNT_W-1:0] TX_PULS_C  = CNT_W'(TX_PULSES);
  localparam logic [CNT_W-1:0] TX_TRAIL_C = CNT_W'(TX_TRAIL);
  localparam logic [CNT_W-1:0] RX_DLY_C   = CNT_W'(RX_DLY);
  localparam logic [CNT_W-1:0] RX_PULS_C  = CNT_W'(RX_PULSES);
  localparam logic [CNT_W-1:0] RX_TRAIL_C = CNT_W'(RX_TRAIL);

  logic       f0_q;
  logic       start_q;
  logic       sel_q;
  logic [2:0] tx_state;
  logic [2:0] rx_state;

  // start_q marks t0 one tick late so the windows open at t0+1.
  always_ff @(posedge c8 or negedge rst_n) begin
    if (!rst_n) begin
      f0_q      <= 1'b0;
      start_q   <= 1'b0;
      sel_q     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      f0_q      <= f0;
      start_q   <= f0_q & ~f0;
      if (f0_q & ~f0) sel_q <= select;
      frame_err <= start_q & busy;
    end
  end

  assign busy = (tx_state != ST_IDLE) | (rx_state != ST_IDLE);

  st_burst_chan #(
    .CNT_W(CNT_W), .HALF(HALF), .EN_TAIL(EN_TAIL), .TRAIL_GAP(TRAIL_GAP)
  ) u_tx (
    .clk      (c8),
    .rst_n    (rst_n),
    .start    (start_q),
    .dly      (sel_q ? RX_DLY_C   : TX_DLY_C),
    .pulses   (sel_q ? RX_PULS_C  : TX_PULS_C),
    .trail    (sel_q ? RX_TRAIL_C : TX_TRAIL_C),
    .en       (clk_en_tx),
    .clk_o    (clk_tx),
    .state_dbg(tx_state)
  );

  st_burst_chan #(
    .CNT_W(CNT_W), .HALF(HALF), .EN_TAIL(EN_TAIL), .TRAIL_GAP(TRAIL_GAP)
  ) u_rx (
    .clk      (c8),
    .rst_n    (rst_n),
    .start    (start_q),
    .dly      (sel_q ? TX_DLY_C   : RX_DLY_C),
    .pulses   (sel_q ? TX_PULS_C  : RX_PULS_C),
    .trail    (sel_q ? TX_TRAIL_C : RX_TRAIL_C),
    .en       (clk_en_rx),
    .clk_o    (clk_rx),
    .state_dbg(rx_state)
  );

endmodule

// File: tb/tb_st_burst_clock_gen.sv
// Bench for st_burst_clock_gen: two parameter sets driven by the same f0/select,
// compared every tick against a window-offset reference model.

module tb_st_burst_clock_gen;

  typedef struct {
    int dly;
    int pulses;
    int trail;
  } set_t;

  localparam int HIST = 16384;

  logic c8 = 1'b0;
  logic rst_n = 1'b0;
  logic f0 = 1'b1;
  logic select = 1'b0;

  logic en_tx1, ctx1, en_rx1, crx1, busy1, err1;
  logic en_tx2, ctx2, en_rx2, crx2, busy2, err2;
  logic [5:0] o1, o2;
  assign o1 = {en_tx1, ctx1, en_rx1, crx1, busy1, err1};
  assign o2 = {en_tx2, ctx2, en_rx2, crx2, busy2, err2};

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #61 c8 = ~c8;

  st_burst_clock_gen u_dut1 (
    .c8(c8), .rst_n(rst_n), .f0(f0), .select(select),
    .clk_en_tx(en_tx1), .clk_tx(ctx1), .clk_en_rx(en_rx1), .clk_rx(crx1),
    .busy(busy1), .frame_err(err1)
  );

  st_burst_clock_gen #(
    .HALF(1), .TX_DLY(0), .TX_PULSES(3), .TX_TRAIL(2),
    .RX_DLY(2), .RX_PULSES(1), .RX_TRAIL(0),
    .EN_TAIL(2), .TRAIL_GAP(3), .CNT_W(8)
  ) u_dut2 (
    .c8(c8), .rst_n(rst_n), .f0(f0), .select(select),
    .clk_en_tx(en_tx2), .clk_tx(ctx2), .clk_en_rx(en_rx2), .clk_rx(crx2),
    .busy(busy2), .frame_err(err2)
  );

  // ---------------- reference model ----------------
  set_t m_set[2][2];
  int   m_half[2];
  int   m_tail[2];
  int   m_gap[2];
  int   ws[2][2];
  int   wsel[2][2];
  int   n = 0;
  int   pend = -1;
  logic pend_sel = 1'b0;
  logic f0_hist = 1'b0;
  int   last_t0 = 0;

  logic [5:0] exp_q1[$];
  logic [5:0] exp_q2[$];
  logic [5:0] obs1[HIST];

  // {active, en, clk} for a window that opened d ticks ago
  function automatic logic [2:0] chan_at(int k, int s, int d);
    set_t p;
    int h, bl, en_end, ts, fin;
    logic act, en, ck;
    p = m_set[k][s];
    h = m_half[k];
    bl = (2 * p.pulses - 1) * h;
    en_end = p.dly + bl + m_tail[k];
    ts = en_end + m_gap[k];
    fin = (p.trail > 0) ? ts + 2 * p.trail * h : en_end;
    if (d < 0) return 3'b000;
    act = (d < fin);
    en = (d < en_end);
    ck = 1'b0;
    if (d >= p.dly && d < p.dly + bl) ck = (((d - p.dly) / h) % 2) == 0;
    if (p.trail > 0 && d >= ts && d < fin) ck = (((d - ts) / h) % 2) == 0;
    return {act, en, ck};
  endfunction

  function automatic logic [2:0] chan_exp(int k, int c, int t);
    if (ws[k][c] < 0) return 3'b000;
    return chan_at(k, wsel[k][c], t - ws[k][c]);
  endfunction

  task automatic model_edge();
    logic [2:0] tx, rx;
    logic err;
    n++;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) for (int c = 0; c < 2; c++) ws[k][c] = -1;
      pend = -1;
      f0_hist = 1'b0;
      exp_q1.push_back(6'b0);
      exp_q2.push_back(6'b0);
      return;
    end
    for (int k = 0; k < 2; k++) begin
      err = 1'b0;
      if (pend == n) begin
        err = chan_exp(k, 0, n - 1)[2] | chan_exp(k, 1, n - 1)[2];
        for (int c = 0; c < 2; c++) begin
          ws[k][c] = n;
          wsel[k][c] = c ^ int'(pend_sel);
        end
      end
      tx = chan_exp(k, 0, n);
      rx = chan_exp(k, 1, n);
      if (k == 0) exp_q1.push_back({tx[1], tx[0], rx[1], rx[0], tx[2] | rx[2], err});
      else        exp_q2.push_back({tx[1], tx[0], rx[1], rx[0], tx[2] | rx[2], err});
    end
    if (pend == n) pend = -1;
    if (f0_hist && !f0) begin
      pend = n + 1;
      pend_sel = select;
      last_t0 = n;
    end
    f0_hist = f0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare();
    logic [5:0] e;
    e = exp_q1.pop_front();
    check($sformatf("dut1_t%0d", n), 32'(o1), 32'(e));
    e = exp_q2.pop_front();
    check($sformatf("dut2_t%0d", n), 32'(o2), 32'(e));
    if (n < HIST) obs1[n] = o1;
  endtask

  function automatic int rises(int b, int from, int to);
    int cnt = 0;
    for (int t = from; t <= to; t++) if (obs1[t][b] && !obs1[t-1][b]) cnt++;
    return cnt;
  endfunction

  function automatic int ones(int b, int from, int to);
    int cnt = 0;
    for (int t = from; t <= to; t++) if (obs1[t][b]) cnt++;
    return cnt;
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input logic f0_v, input logic sel_v);
    f0 = f0_v;
    select = sel_v;
    @(posedge c8);
    model_edge();
    @(negedge c8);
    compare();
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic async_reset(input int hold, input logic f0_v);
    #5 rst_n = 1'b0;
    #1;
    check("rst_async_dut1", 32'(o1), 32'h0);
    check("rst_async_dut2", 32'(o2), 32'h0);
    for (int i = 0; i < hold; i++) step(f0_v, 1'($urandom_range(0, 1)));
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int t1, t2, t3, t4, ta, tb, tr, tf;
  int lo, hi, sel_kind;

  initial begin
    m_set[0][0] = '{1, 31, 1};
    m_set[0][1] = '{4, 32, 0};
    m_half[0] = 2; m_tail[0] = 1; m_gap[0] = 1;
    m_set[1][0] = '{0, 3, 2};
    m_set[1][1] = '{2, 1, 0};
    m_half[1] = 1; m_tail[1] = 2; m_gap[1] = 3;
    for (int k = 0; k < 2; k++) for (int c = 0; c < 2; c++) begin
      ws[k][c] = -1;
      wsel[k][c] = 0;
    end

    // reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // defaults, select=0, single-tick f0 low
    step(1'b0, 1'b0); t1 = last_t0;
    idle(220);
    check("s1_en_tx_before", 32'(obs1[t1][5]), 0);
    check("s1_en_tx_ones", ones(5, t1 + 1, t1 + 124), 124);
    check("s1_en_tx_fall", 32'(obs1[t1 + 125][5]), 0);
    for (int k = 0; k <= 30; k++)
      check($sformatf("s1_tx_rise%0d", k), 32'({obs1[t1 + 1 + 4*k][4], obs1[t1 + 2 + 4*k][4], obs1[t1 + 3 + 4*k][4]}), 32'b011);
    check("s1_tx_rises_win", rises(4, t1 + 1, t1 + 125), 31);
    check("s1_tx_trail", 32'({obs1[t1 + 125][4], obs1[t1 + 126][4], obs1[t1 + 127][4], obs1[t1 + 128][4]}), 32'b0110);
    check("s1_tx_rises_all", rises(4, t1 + 1, t1 + 220), 32);
    check("s1_en_rx_ones", ones(3, t1 + 1, t1 + 131), 131);
    check("s1_en_rx_fall", 32'(obs1[t1 + 132][3]), 0);
    for (int k = 0; k <= 31; k++)
      check($sformatf("s1_rx_rise%0d", k), 32'({obs1[t1 + 4 + 4*k][2], obs1[t1 + 5 + 4*k][2]}), 32'b01);
    check("s1_rx_last_fall", 32'({obs1[t1 + 130][2], obs1[t1 + 131][2]}), 32'b10);
    check("s1_rx_rises_all", rises(2, t1 + 1, t1 + 220), 32);
    check("s1_busy_fall", 32'({obs1[t1 + 131][1], obs1[t1 + 132][1]}), 32'b10);

    // select=1 swaps the pulse trains
    step(1'b0, 1'b1); t2 = last_t0;
    idle(220);
    check("s2_tx_first", 32'({obs1[t2 + 4][4], obs1[t2 + 5][4]}), 32'b01);
    check("s2_tx_rises", rises(4, t2 + 1, t2 + 220), 32);
    check("s2_tx_quiet", rises(4, t2 + 132, t2 + 220), 0);
    check("s2_rx_first", 32'({obs1[t2 + 1][2], obs1[t2 + 2][2]}), 32'b01);
    check("s2_rx_rises_win", rises(2, t2 + 1, t2 + 125), 31);
    check("s2_rx_trail", 32'({obs1[t2 + 125][2], obs1[t2 + 126][2]}), 32'b01);
    check("s2_rx_rises_all", rises(2, t2 + 1, t2 + 220), 32);

    // retrigger at t0+60
    step(1'b0, 1'b0); t3 = last_t0;
    idle(59);
    step(1'b0, 1'b0);
    idle(250);
    check("s3_err", 32'({obs1[t3 + 60][0], obs1[t3 + 61][0], obs1[t3 + 62][0]}), 32'b010);
    check("s3_en_tx_cont", ones(5, t3 + 1, t3 + 184), 184);
    check("s3_en_rx_cont", ones(3, t3 + 1, t3 + 191), 191);
    check("s3_clk_zero", 32'({obs1[t3 + 61][4], obs1[t3 + 61][2]}), 32'b00);
    check("s3_tx_rerise", 32'(obs1[t3 + 62][4]), 1);
    check("s3_rx_rerise", 32'({obs1[t3 + 64][2], obs1[t3 + 65][2]}), 32'b01);
    check("s3_tx_rises", rises(4, t3 + 61, t3 + 185), 31);
    check("s3_rx_rises", rises(2, t3 + 61, t3 + 192), 32);

    // async reset mid-burst, f0 held low through release
    step(1'b0, 1'b0); t4 = last_t0;
    idle(39);
    async_reset(4, 1'b0);
    tr = n;
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)));
    check("s4_quiet_tx", rises(4, tr + 1, tr + 20) + ones(5, tr + 1, tr + 20), 0);
    check("s4_quiet_rx", rises(2, tr + 1, tr + 20) + ones(3, tr + 1, tr + 20), 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("s4_restart_en", 32'(obs1[last_t0 + 0][5]), 0);
    idle(200);
    check("s4_restart_rises", rises(4, last_t0 + 1, last_t0 + 200), 32);

    // start exactly when busy drops: no frame error
    step(1'b0, 1'b0); ta = last_t0;
    idle(131);
    step(1'b0, 1'b0); tb = last_t0;
    check("s7_boundary_t0", tb - ta, 132);
    idle(130);
    check("s7_no_err", 32'({obs1[tb + 1][0], obs1[tb + 1][5]}), 32'b01);
    // one tick earlier: RX still active
    step(1'b0, 1'b0);
    check("s8_boundary_t0", last_t0 - tb, 131);
    idle(250);
    check("s8_err", 32'(obs1[last_t0 + 1][0]), 1);

    // periodic frames every 1024 ticks
    for (int f = 0; f < 4; f++) begin
      step(1'b0, 1'b0); tf = last_t0;
      for (int i = 0; i < 1023; i++) step(1'b1, 1'b0);
      check($sformatf("s5_f%0d_tx_rises", f), rises(4, tf + 1, tf + 1023), 32);
      check($sformatf("s5_f%0d_rx_rises", f), rises(2, tf + 1, tf + 1023), 32);
      check($sformatf("s5_f%0d_err", f), ones(0, tf, tf + 1023), 0);
      check($sformatf("s5_f%0d_busy_gap", f), ones(1, tf + 140, tf + 1023), 0);
    end

    // randomized frames, retriggers, select changes and resets
    while (n < 12500) begin
      lo = $urandom_range(1, 3);
      for (int i = 0; i < lo; i++) step(1'b0, 1'($urandom_range(0, 1)));
      sel_kind = $urandom_range(0, 3);
      case (sel_kind)
        0: hi = $urandom_range(1, 5);
        1: hi = $urandom_range(40, 140);
        2: hi = $urandom_range(125, 135);
        default: hi = $urandom_range(200, 400);
      endcase
      for (int i = 0; i < hi; i++) step(1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) async_reset($urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
    idle(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
